// File: rtl/mux_scan_capture.sv
// mux_scan_capture: walks the select of a 16-to-1 bit mux through 0..15,
// samples the mux output once per select value after a programmable dwell,
// and assembles the samples into a 16-bit word ({d, c, b, a} of the mux
// sources). Single-shot or continuous scanning with start/busy/valid handshake.
module mux_scan_capture #(
  parameter int SETTLE_CYCLES = 1   // dwell per select value, legal 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cont,
  input  logic        abort,
  input  logic        mux_out,
  output logic [3:0]  sel,
  output logic        busy,
  output logic [15:0] word,
  output logic        word_valid
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Dwell counter reload: the sample happens when the counter reaches zero,
  // so a value of SETTLE_CYCLES-1 holds each select for SETTLE_CYCLES cycles.
  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] SEL_LAST = 4'd15;

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cont_q, cont_d;
  // Bit 15 never needs storing: the last sample goes straight into the word.
  logic [14:0] shadow_q, shadow_d;
  logic [15:0] word_q, word_d;
  logic        valid_q, valid_d;

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= 4'd0;
      cnt_q    <= 4'd0;
      cont_q   <= 1'b0;
      shadow_q <= 15'd0;
      word_q   <= 16'h0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      cont_q   <= cont_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state and datapath update: start acceptance, dwell, sampling, abort.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    cont_d   = cont_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    valid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_SCAN;
          sel_d    = 4'd0;
          cnt_d    = RELOAD;
          cont_d   = cont;
          shadow_d = 15'd0;
        end else begin
          sel_d = 4'd0;
        end
      end

      ST_SCAN: begin
        if (abort) begin
          // Abort beats a coincident final sample: no word, no pulse.
          state_d = ST_IDLE;
          sel_d   = 4'd0;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (sel_q != SEL_LAST) begin
          shadow_d[sel_q] = mux_out;
          sel_d           = sel_q + 4'd1;
          cnt_d           = RELOAD;
        end else begin
          word_d  = {mux_out, shadow_q};
          valid_d = 1'b1;
          sel_d   = 4'd0;
          if (cont_q) begin
            // Continuous: wrap straight into the next word, no gap cycle.
            cnt_d    = RELOAD;
            shadow_d = 15'd0;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = 4'd0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    sel        = sel_q;
    busy       = (state_q == ST_SCAN);
    word       = word_q;
    word_valid = valid_q;
  end

endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed bench for mux_scan_capture: a table of source patterns with
// hand-computed words, plus hand-written sequences for dwell, continuous
// mode, abort on the final sample, held start and asynchronous reset.
module tb_mux_scan_capture;

  logic        clk;
  logic        rst_n;
  logic        start1, start3;
  logic        cont;
  logic        abort1, abort3;
  logic        mux1, mux3;
  logic [3:0]  sel1, sel3;
  logic        busy1, busy3;
  logic [15:0] word1, word3;
  logic        valid1, valid3;

  logic [3:0]  src_a, src_b, src_c, src_d;
  logic [15:0] src_w;

  int n_checks;
  int n_pass;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  c;
    logic [3:0]  d;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs [6];

  // Model of the 16-to-1 mux feeding each DUT.
  assign src_w = {src_d, src_c, src_b, src_a};
  assign mux1  = src_w[sel1];
  assign mux3  = src_w[sel3];

  mux_scan_capture #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .cont       (cont),
    .abort      (abort1),
    .mux_out    (mux1),
    .sel        (sel1),
    .busy       (busy1),
    .word       (word1),
    .word_valid (valid1)
  );

  mux_scan_capture #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start3),
    .cont       (cont),
    .abort      (abort3),
    .mux_out    (mux3),
    .sel        (sel3),
    .busy       (busy3),
    .word       (word3),
    .word_valid (valid3)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_src(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    src_a = a; src_b = b; src_c = c; src_d = d;
  endtask

  // One-cycle start pulse on the SETTLE_CYCLES=1 instance.
  task automatic pulse_start1(input logic c);
    start1 = 1'b1;
    cont   = c;
    tick();
    start1 = 1'b0;
    cont   = 1'b0;
  endtask

  // Tick until valid1 is seen (bounded); reports the number of ticks taken.
  task automatic wait_valid1(input int max_cyc, output int cyc);
    cyc = 0;
    while (!valid1 && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    if (!valid1) begin
      chk("valid_timeout", 32'(valid1), 32'd1);
    end
  endtask

  initial begin
    int cyc;
    int pulses;
    n_checks = 0;
    n_pass   = 0;
    rst_n  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    cont   = 1'b0;
    abort1 = 1'b0;
    abort3 = 1'b0;
    set_src(4'h5, 4'h3, 4'hC, 4'h9);

    vecs[0] = '{a: 4'h5, b: 4'h3, c: 4'hC, d: 4'h9, exp_word: 16'h9C35};
    vecs[1] = '{a: 4'hF, b: 4'h0, c: 4'h0, d: 4'h1, exp_word: 16'h100F};
    vecs[2] = '{a: 4'h0, b: 4'h0, c: 4'h0, d: 4'h0, exp_word: 16'h0000};
    vecs[3] = '{a: 4'hF, b: 4'hF, c: 4'hF, d: 4'hF, exp_word: 16'hFFFF};
    vecs[4] = '{a: 4'h1, b: 4'h2, c: 4'h4, d: 4'h8, exp_word: 16'h8421};
    vecs[5] = '{a: 4'hA, b: 4'h5, c: 4'hA, d: 4'h5, exp_word: 16'h5A5A};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_sel", 32'(sel1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_word", 32'(word1), 32'd0);
    chk("rst_valid", 32'(valid1), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single scan, SETTLE_CYCLES=1: sel steps 0..15 with busy high.
    pulse_start1(1'b0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("single_sel%0d", k), 32'(sel1), 32'(k));
      chk($sformatf("single_busy%0d", k), 32'(busy1), 32'd1);
      chk($sformatf("single_novalid%0d", k), 32'(valid1), 32'd0);
      tick();
    end
    chk("single_valid", 32'(valid1), 32'd1);
    chk("single_word", 32'(word1), 32'h9C35);
    chk("single_busy_end", 32'(busy1), 32'd0);
    chk("single_sel_end", 32'(sel1), 32'd0);
    tick();
    chk("single_valid_1cyc", 32'(valid1), 32'd0);

    // Dwell, SETTLE_CYCLES=3: each select held three cycles, 48 to valid.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("dwell_sel%0d_%0d", k, j), 32'(sel3), 32'(k));
        chk($sformatf("dwell_novalid%0d_%0d", k, j), 32'(valid3), 32'd0);
        tick();
      end
    end
    chk("dwell_valid", 32'(valid3), 32'd1);
    chk("dwell_word", 32'(word3), 32'h9C35);
    chk("dwell_busy_end", 32'(busy3), 32'd0);
    tick();

    // Table of source patterns through single scans.
    for (int v = 0; v < 6; v++) begin
      set_src(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d);
      pulse_start1(1'b0);
      wait_valid1(100, cyc);
      chk($sformatf("tab%0d_cycles", v), 32'(cyc), 32'd16);
      chk($sformatf("tab%0d_word", v), 32'(word1), 32'(vecs[v].exp_word));
      chk($sformatf("tab%0d_busy", v), 32'(busy1), 32'd0);
      tick();
    end

    // Continuous: sources change during the second word.
    set_src(4'h5, 4'h3, 4'hC, 4'h9);
    pulse_start1(1'b1);
    wait_valid1(100, cyc);
    chk("cont_cycles1", 32'(cyc), 32'd16);
    chk("cont_word1", 32'(word1), 32'h9C35);
    chk("cont_busy1", 32'(busy1), 32'd1);
    chk("cont_sel_wrap", 32'(sel1), 32'd0);
    set_src(4'hF, 4'h0, 4'h0, 4'h1);
    tick();
    wait_valid1(100, cyc);
    chk("cont_gap", 32'(cyc + 1), 32'd16);
    chk("cont_word2", 32'(word1), 32'h100F);
    chk("cont_busy2", 32'(busy1), 32'd1);
    tick();
    tick();
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("cont_abort_busy", 32'(busy1), 32'd0);
    chk("cont_abort_sel", 32'(sel1), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid1) pulses++;
      tick();
    end
    chk("cont_abort_nopulse", 32'(pulses), 32'd0);
    chk("cont_abort_word", 32'(word1), 32'h100F);

    // Abort coinciding with the sel==15 sample edge.
    set_src(4'hF, 4'hF, 4'hF, 4'hF);
    pulse_start1(1'b0);
    repeat (15) tick();
    chk("ab15_sel", 32'(sel1), 32'd15);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("ab15_novalid", 32'(valid1), 32'd0);
    chk("ab15_busy", 32'(busy1), 32'd0);
    chk("ab15_word", 32'(word1), 32'h100F);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid1) pulses++;
      tick();
    end
    chk("ab15_nopulse", 32'(pulses), 32'd0);

    // start and abort together in IDLE: stays IDLE.
    start1 = 1'b1;
    abort1 = 1'b1;
    tick();
    start1 = 1'b0;
    abort1 = 1'b0;
    chk("idle_abort_busy", 32'(busy1), 32'd0);
    chk("idle_abort_word", 32'(word1), 32'h100F);

    // start held high, single mode: one IDLE cycle between scans.
    set_src(4'h5, 4'h3, 4'hC, 4'h9);
    start1 = 1'b1;
    tick();
    wait_valid1(100, cyc);
    chk("held_cycles1", 32'(cyc), 32'd16);
    chk("held_word1", 32'(word1), 32'h9C35);
    chk("held_idle", 32'(busy1), 32'd0);
    tick();
    chk("held_restart_busy", 32'(busy1), 32'd1);
    chk("held_restart_sel", 32'(sel1), 32'd0);
    chk("held_restart_novalid", 32'(valid1), 32'd0);
    set_src(4'h1, 4'h2, 4'h4, 4'h8);
    wait_valid1(100, cyc);
    chk("held_cycles2", 32'(cyc), 32'd16);
    chk("held_word2", 32'(word1), 32'h8421);
    chk("held_idle2", 32'(busy1), 32'd0);
    start1 = 1'b0;
    tick();
    chk("held_release_busy", 32'(busy1), 32'd0);

    // Asynchronous reset mid-scan at sel=7.
    pulse_start1(1'b0);
    repeat (7) tick();
    chk("mid_sel7", 32'(sel1), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(sel1), 32'd0);
    chk("arst_busy", 32'(busy1), 32'd0);
    chk("arst_word", 32'(word1), 32'd0);
    chk("arst_valid", 32'(valid1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_idle_busy", 32'(busy1), 32'd0);
    chk("arst_idle_sel", 32'(sel1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
